// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: byte width, FSM states and the
// round-robin rotation helper.
package uart_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Rotates req so that bit 0 holds requester ptr and bit n-1 holds ptr-1.
    function automatic logic [MAX_REQ-1:0] rotate_prio(
        input logic [MAX_REQ-1:0] req,
        input int                 ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] rot;
        int                 src;
        rot = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                src = i + ptr;
                if (src >= n) begin
                    src = src - n;
                end
                rot[i] = req[src];
            end
        end
        return rot;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; pure function of the request vector and pointer.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    logic [MAX_REQ-1:0] rot;
    int                 off;
    int                 idx;

    always_comb begin
        rot = rotate_prio(MAX_REQ'(req), int'(ptr), NUM_REQ);
        off = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        idx = int'(ptr) + off;
        if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
        end
        grant = IDX_W'(idx);
        any   = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one byte-wide UART TX among NUM_REQ sources.
// Latency: 1 cycle from valid to grant, then zero-latency combinational forwarding.
// Backpressure: i_tx_ready reaches only the owner; every other requester sees ready=0.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int IDLE_TIMEOUT = 1024,
    localparam int TO_W         = $clog2(IDLE_TIMEOUT + 1),
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_last,
    input  logic [BYTE_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [BYTE_W-1:0]         o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_busy,
    output logic [IDX_W-1:0]          o_owner,
    output logic                      o_timeout
);

    // A disabled timeout still needs a 1-bit counter to keep the logic legal.
    localparam int               CNT_W    = (TO_W > 0) ? TO_W : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] owner_inc;
    logic             pick_any;
    logic             own_vld;
    logic             own_last;
    logic             beat;
    logic             stall_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (i_req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign own_vld    = i_req_valid[owner_q];
    assign own_last   = i_req_last[owner_q];
    assign beat       = own_vld && i_tx_ready;
    assign owner_inc  = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    // Fires on the stall cycle that brings the count to IDLE_TIMEOUT; a ready
    // stall with valid high never gets here because the counter only moves on valid low.
    assign stall_fire = (IDLE_TIMEOUT != 0) && !own_vld && (to_cnt_q >= CNT_FIRE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        to_cnt_d    = to_cnt_q;
        o_req_ready = '0;
        o_tx_data   = '0;
        o_tx_valid  = 1'b0;
        o_busy      = 1'b0;
        o_owner     = owner_q;
        o_timeout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_LOCKED;
                    owner_d  = pick_idx;
                    to_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                o_busy               = 1'b1;
                o_tx_valid           = own_vld;
                o_tx_data            = i_req_data[owner_q*BYTE_W +: BYTE_W];
                o_req_ready[owner_q] = i_tx_ready;
                // A last beat wins over a coincident timeout, so it is tested first.
                if (beat) begin
                    to_cnt_d = '0;
                    if (own_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end else if (stall_fire) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = owner_inc;
                    to_cnt_d  = '0;
                    o_timeout = 1'b1;
                end else if (!own_vld && (to_cnt_q != CNT_MAX)) begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: constant vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic [1:0]     owner;
    logic           timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (req_valid),
        .i_req_last  (req_last),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_owner     (owner),
        .o_timeout   (timeout)
    );

    // Reference model: who holds the line (-1 = nobody), where the next scan
    // starts, and how many consecutive cycles the holder has had nothing to send.
    int           m_hold;
    int           m_ptr;
    int           m_idle;
    logic [N-1:0] e_rdy;

    logic         d_busy, d_txv, d_to;
    logic [1:0]   d_owner;
    logic [7:0]   d_txd;
    logic [N-1:0] d_rdy;

    typedef struct {
        logic           rst;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        logic           tr;
        logic           busy;
        logic [1:0]     own;
        logic           txv;
        logic [7:0]     txd;
        logic [N-1:0]   rdy;
        logic           to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic tr, input logic b,
                                input logic [1:0] own, input logic txv, input logic [7:0] txd,
                                input logic [3:0] rdy, input logic to);
        vec_t r;
        r.rst = rst; r.v = v; r.l = l; r.d = d; r.tr = tr;
        r.busy = b; r.own = own; r.txv = txv; r.txd = txd; r.rdy = rdy; r.to = to;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst  = 1'b0;
        m_hold = -1;
        m_ptr  = 0;
        m_idle = 0;
    endtask

    // Called at a negedge with this cycle's inputs applied; checks the DUT
    // against the model, advances the model across the coming posedge.
    task automatic tick(input string tag);
        logic       e_busy, e_txv, e_to;
        logic [7:0] e_txd;
        int         h;
        #1;
        h      = m_hold;
        e_busy = (h >= 0);
        e_txv  = 1'b0;
        e_txd  = 8'h00;
        e_to   = 1'b0;
        e_rdy  = '0;
        if (h >= 0) begin
            e_txv    = req_valid[h];
            e_txd    = req_data[8*h +: 8];
            e_rdy[h] = tx_ready;
            e_to     = !req_valid[h] && (m_idle + 1 >= TO);
        end
        d_busy = busy; d_txv = tx_valid; d_to = timeout;
        d_owner = owner; d_txd = tx_data; d_rdy = req_ready;
        chk($sformatf("%s busy", tag), int'(busy), int'(e_busy));
        chk($sformatf("%s tx_valid", tag), int'(tx_valid), int'(e_txv));
        chk($sformatf("%s tx_data", tag), int'(tx_data), int'(e_txd));
        chk($sformatf("%s req_ready", tag), int'(req_ready), int'(e_rdy));
        chk($sformatf("%s timeout", tag), int'(timeout), int'(e_to));
        if (e_busy) begin
            chk($sformatf("%s owner", tag), int'(owner), h);
        end
        if (i_rst) begin
            m_hold = -1; m_ptr = 0; m_idle = 0;
        end else if (h < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_hold < 0 && req_valid[(m_ptr + i) % N]) begin
                    m_hold = (m_ptr + i) % N;
                    m_idle = 0;
                end
            end
        end else if (req_valid[h] && tx_ready) begin
            m_idle = 0;
            if (req_last[h]) begin
                m_ptr  = (h + 1) % N;
                m_hold = -1;
            end
        end else if (e_to) begin
            m_ptr  = (h + 1) % N;
            m_hold = -1;
            m_idle = 0;
        end else if (!req_valid[h]) begin
            m_idle++;
        end
        @(negedge i_clk);
    endtask

    int           pkt_left [N];
    int           pause    [N];
    logic [7:0]   cur      [N];
    int           served   [$];

    initial begin
        do_reset();

        // Contention from reset release (0,2,3), then a timeout with req3 pending.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1101, 4'b0000, 32'hD0C0_00A0, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1101, 4'b0000, 32'hD0C0_00A0, 1, 1, 0, 1, 8'hA0, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b1101, 4'b0001, 32'hD0C0_00A1, 1, 1, 0, 1, 8'hA1, 4'b0001, 0));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 32'hD0C0_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 32'hD0C0_0000, 1, 1, 2, 1, 8'hC0, 4'b0100, 0));
        tbl.push_back(mk(0, 4'b1100, 4'b0100, 32'hD0C1_0000, 1, 1, 2, 1, 8'hC1, 4'b0100, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD000_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'hD000_0000, 1, 1, 3, 1, 8'hD0, 4'b1000, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'hD100_0000, 1, 1, 3, 1, 8'hD1, 4'b1000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0010_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0010_0000, 1, 1, 2, 1, 8'h10, 4'b0100, 0));
        for (int s = 1; s <= TO; s++) begin
            tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'h3000_0000, 1, 1, 2, 0, 8'h00, 4'b0100,
                             (s == TO) ? 1'b1 : 1'b0));
        end
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'h3000_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'h3000_0000, 1, 1, 3, 1, 8'h30, 4'b1000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 0, 0, 8'h00, 4'b0000, 0));

        foreach (tbl[i]) begin
            i_rst = tbl[i].rst; req_valid = tbl[i].v; req_last = tbl[i].l;
            req_data = tbl[i].d; tx_ready = tbl[i].tr;
            #1;
            chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("vec%0d tx_valid", i), int'(tx_valid), int'(tbl[i].txv));
            chk($sformatf("vec%0d tx_data", i), int'(tx_data), int'(tbl[i].txd));
            chk($sformatf("vec%0d req_ready", i), int'(req_ready), int'(tbl[i].rdy));
            chk($sformatf("vec%0d timeout", i), int'(timeout), int'(tbl[i].to));
            if (tbl[i].busy) begin
                chk($sformatf("vec%0d owner", i), int'(owner), int'(tbl[i].own));
            end
            @(negedge i_clk);
        end

        // Single 3-byte packet from req1 with tx_ready pulsing once per 10 cycles.
        do_reset();
        begin
            int idx = 0, beats = 0, c = 0;
            while (idx < 3 && c < 200) begin
                req_valid = 4'b0010;
                req_last  = (idx == 2) ? 4'b0010 : 4'b0000;
                req_data  = {16'h0000, 8'(8'h41 + idx), 8'h00};
                tx_ready  = (c % 10 == 9);
                tick("pkt");
                if (d_txv && tx_ready) begin
                    chk("pkt byte order", int'(d_txd), 8'h41 + beats);
                    beats++;
                end
                if (req_valid[1] && e_rdy[1]) idx++;
                c++;
            end
            chk("pkt beats", beats, 3);
            req_valid = 4'b1101; req_last = 4'b1101; req_data = 32'h3320_0010; tx_ready = 1'b1;
            tick("pkt");
            chk("pkt idle after last", int'(d_busy), 0);
            tick("pkt");
            chk("pkt rr_ptr resumes at 2", int'(d_owner), 2);
        end

        // Fairness: req0 streams 2-byte packets, req1 posts one packet.
        do_reset();
        begin
            int   r0_idx = 0;
            logic r1_done = 1'b0;
            served.delete();
            for (int c = 0; c < 12; c++) begin
                req_valid[0]    = 1'b1;
                req_last[0]     = (r0_idx == 1);
                req_data[7:0]   = 8'(8'hA0 + r0_idx);
                req_valid[1]    = (c >= 1) && !r1_done;
                req_last[1]     = 1'b1;
                req_data[15:8]  = 8'hB1;
                req_valid[3:2]  = 2'b00;
                req_last[3:2]   = 2'b00;
                tx_ready        = 1'b1;
                tick("fair");
                if (d_busy && d_txv && tx_ready && req_last[d_owner]) served.push_back(int'(d_owner));
                if (req_valid[0] && e_rdy[0]) r0_idx = 1 - r0_idx;
                if (req_valid[1] && e_rdy[1]) r1_done = 1'b1;
            end
            chk("fair packets served", (served.size() >= 3) ? 1 : 0, 1);
            if (served.size() >= 3) begin
                chk("fair order 0", served[0], 0);
                chk("fair order 1", served[1], 1);
                chk("fair order 2", served[2], 0);
            end
        end

        // Backpressure with valid held high must not count toward the timeout.
        do_reset();
        begin
            int tos = 0;
            req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h0000_7700; tx_ready = 1'b0;
            repeat (52) begin
                tick("bp");
                if (d_to) tos++;
            end
            chk("bp no timeout", tos, 0);
            tx_ready = 1'b1;
            tick("bp");
            chk("bp ready on rise", int'(d_rdy), 4'b0010);
            chk("bp data", int'(d_txd), 8'h77);
            req_valid = '0;
            tick("bp");
        end

        // Reset in the middle of a 4-byte packet from req1, with rr_ptr moved to 3 first.
        do_reset();
        req_valid = 4'b0100; req_last = 4'b0100; req_data = 32'h0022_0000; tx_ready = 1'b1;
        tick("rst");
        tick("rst");
        req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h0000_5000;
        tick("rst");
        for (int b = 0; b < 2; b++) begin
            req_data[15:8] = 8'(8'h50 + b);
            tick("rst");
        end
        req_data[15:8] = 8'h52;
        i_rst = 1'b1;
        tick("rst");
        i_rst = 1'b0;
        req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'hD300_00C0;
        tick("rst");
        chk("rst busy cleared", int'(d_busy), 0);
        chk("rst tx_valid cleared", int'(d_txv), 0);
        chk("rst ready cleared", int'(d_rdy), 0);
        tick("rst");
        chk("rst rr_ptr restart", int'(d_owner), 0);

        // Randomized traffic with pauses long enough to provoke timeouts.
        do_reset();
        for (int k = 0; k < N; k++) begin
            pkt_left[k] = 0; pause[k] = 0; cur[k] = 8'h00;
        end
        repeat (4000) begin
            for (int k = 0; k < N; k++) begin
                if (pause[k] > 0) begin
                    pause[k]--;
                    req_valid[k] = 1'b0;
                end else begin
                    if (pkt_left[k] == 0 && $urandom_range(0, 3) == 0) begin
                        pkt_left[k] = int'($urandom_range(1, 4));
                        cur[k]      = 8'($urandom);
                    end
                    if ($urandom_range(0, 29) == 0) pause[k] = int'($urandom_range(1, 14));
                    req_valid[k] = (pkt_left[k] > 0) && (pause[k] == 0) && ($urandom_range(0, 9) < 8);
                end
                req_last[k]        = (pkt_left[k] == 1);
                req_data[8*k +: 8] = cur[k];
            end
            tx_ready = ($urandom_range(0, 2) != 0);
            tick("rand");
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && e_rdy[k]) begin
                    pkt_left[k]--;
                    cur[k] = 8'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
